// File: rtl/sprite_spawn_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_spawn_ctrl
//
// Game-round sequencer for the HDMI sprite path. A debounced button press
// spawns the sprite at a pseudo-random centre position. A second press made
// while the sprite is up scores a hit and shows the "popped" variant for a
// few frames. If no press arrives in time, the round scores a miss.
//
// Event semantics: there is no valid/ready handshake in this block. Both
// events are single-cycle, level-sampled pulses that are consumed in the
// cycle they are high:
//   - new_frame_in comes from video_sig_gen.
//   - The internal press pulse comes from the debouncer.
// Nothing is queued. An event that arrives in a state that ignores it is
// dropped.
//
// Ports:
//   clk_in        pixel clock
//   rst_in        asynchronous, active-high reset
//   btn_in        raw push button, active high, asynchronous to clk_in
//   new_frame_in  one-cycle pulse per video frame
//   x_com_out     sprite centre x (11 bits)
//   y_com_out     sprite centre y (10 bits)
//   visible_out   sprite is to be drawn
//   pop_out       pop-variant select for image_sprite2
//   hits_out      saturating hit counter
//   misses_out    saturating miss counter
//   state_out     FSM state: 0 IDLE, 1 SHOW, 2 POP
// ---------------------------------------------------------------------------
module sprite_spawn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 742500,
  parameter int SHOW_FRAMES     = 120,
  parameter int POP_FRAMES      = 30,
  parameter int X_BASE          = 128,
  parameter int Y_BASE          = 232
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_in,
  input  logic        new_frame_in,
  output logic [10:0] x_com_out,
  output logic [9:0]  y_com_out,
  output logic        visible_out,
  output logic        pop_out,
  output logic [7:0]  hits_out,
  output logic [7:0]  misses_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_POP  = 2'd2
  } state_t;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] LFSR_SEED = 20'hACE1;
  localparam logic [7:0] SHOW_LOAD = 8'(SHOW_FRAMES);
  localparam logic [7:0] POP_LOAD  = 8'(POP_FRAMES);

  // -------------------------------------------------------------------------
  // Input conditioning: synchronizer, debouncer, press edge detect
  // -------------------------------------------------------------------------
  logic             sync1_q, sync2_q;
  logic             deb_lvl_q, deb_lvl_d;
  logic             deb_dly_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press_q, press_d;
  logic [19:0]      lfsr_q, lfsr_d;

  // The counter tracks consecutive samples that disagree with the accepted
  // level. On the DEBOUNCE_CYCLES-th such sample the level flips.
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    if (sync2_q != deb_lvl_q) begin
      if (deb_cnt_q == CNT_LAST) begin
        deb_lvl_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  // The press is registered one cycle after the debounced level rises.
  // Release produces no event.
  assign press_d = deb_lvl_q & ~deb_dly_q;

  // Fibonacci LFSR for x^20 + x^17 + 1. It runs every cycle so that the
  // spawn position depends on the exact moment of the press.
  assign lfsr_d = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_lvl_q <= 1'b0;
      deb_dly_q <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      deb_lvl_q <= deb_lvl_d;
      deb_dly_q <= deb_lvl_q;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Round FSM
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  frame_q, frame_d;
  logic [7:0]  hits_q, hits_d;
  logic [7:0]  misses_q, misses_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        vis_q, vis_d;
  logic        pop_q, pop_d;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    x_d      = x_q;
    y_d      = y_q;
    case (state_q)
      S_IDLE: begin
        if (press_q) begin
          x_d     = 11'(X_BASE) + {1'b0, lfsr_q[9:0]};
          y_d     = 10'(Y_BASE) + {2'b00, lfsr_q[17:10]};
          frame_d = SHOW_LOAD;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        // A press wins over a coincident frame tick, including the final tick.
        if (press_q) begin
          hits_d  = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
          frame_d = POP_LOAD;
          state_d = S_POP;
        end else if (new_frame_in) begin
          frame_d = frame_q - 8'd1;
          if (frame_q == 8'd1) begin
            misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
            state_d  = S_IDLE;
          end
        end
      end
      S_POP: begin
        if (new_frame_in) begin
          frame_d = frame_q - 8'd1;
          if (frame_q == 8'd1) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        frame_d = '0;
      end
    endcase
    // Outputs are registered, so they are decoded from the next state.
    vis_d = (state_d == S_SHOW) || (state_d == S_POP);
    pop_d = (state_d == S_POP);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      vis_q    <= 1'b0;
      pop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vis_q    <= vis_d;
      pop_q    <= pop_d;
    end
  end

  assign x_com_out   = x_q;
  assign y_com_out   = y_q;
  assign visible_out = vis_q;
  assign pop_out     = pop_q;
  assign hits_out    = hits_q;
  assign misses_out  = misses_q;
  assign state_out   = state_q;

endmodule
